// File: rtl/cbfp1_shift_calc.sv
// CBFP stage-1 shift calculator: per-group minimum redundant-sign-bit count for the add and
// sub paths, with ping-pong beat buffers that replay data aligned to the shift values.
// Optional macro CBFP1_SHIFT_CLAMP_EN limits each shift output to SHIFT_TARGET.
module cbfp1_shift_calc #(
  parameter int INPUT_WIDTH  = 25,
  parameter int BLOCK_SIZE   = 8,
  parameter int SHIFT_WIDTH  = 5,
  parameter int BLOCK_BEATS  = 2,
  parameter int SHIFT_TARGET = 13
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic signed [INPUT_WIDTH-1:0] in_data_R_add  [BLOCK_SIZE],
  input  logic signed [INPUT_WIDTH-1:0] in_data_Q_add  [BLOCK_SIZE],
  input  logic signed [INPUT_WIDTH-1:0] in_data_R_sub  [BLOCK_SIZE],
  input  logic signed [INPUT_WIDTH-1:0] in_data_Q_sub  [BLOCK_SIZE],
  output logic                          out_valid,
  output logic                          out_first,
  output logic                          out_last,
  output logic signed [INPUT_WIDTH-1:0] out_data_R_add [BLOCK_SIZE],
  output logic signed [INPUT_WIDTH-1:0] out_data_Q_add [BLOCK_SIZE],
  output logic signed [INPUT_WIDTH-1:0] out_data_R_sub [BLOCK_SIZE],
  output logic signed [INPUT_WIDTH-1:0] out_data_Q_sub [BLOCK_SIZE],
  output logic [SHIFT_WIDTH-1:0]        shift_value_add,
  output logic [SHIFT_WIDTH-1:0]        shift_value_sub
);
  // Handshake: in_valid qualifies one beat per rising edge and there is no ready in either
  // direction; once a bank is full its beats leave on out_valid in consecutive cycles.

  localparam int CNT_W = $clog2(INPUT_WIDTH);
  localparam int BW    = (BLOCK_BEATS > 1) ? $clog2(BLOCK_BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(INPUT_WIDTH - 1);
  localparam logic [BW-1:0]    LAST_BEAT = BW'(BLOCK_BEATS - 1);

  logic signed [INPUT_WIDTH-1:0] mem_ra [2][BLOCK_BEATS][BLOCK_SIZE];
  logic signed [INPUT_WIDTH-1:0] mem_qa [2][BLOCK_BEATS][BLOCK_SIZE];
  logic signed [INPUT_WIDTH-1:0] mem_rs [2][BLOCK_BEATS][BLOCK_SIZE];
  logic signed [INPUT_WIDTH-1:0] mem_qs [2][BLOCK_BEATS][BLOCK_SIZE];

  logic [BW-1:0]    beat_cnt_q;
  logic [BW-1:0]    drain_cnt_q;
  logic             fill_ptr_q;
  logic             drain_ptr_q;
  logic [1:0]       full_q;
  logic [CNT_W-1:0] run_min_add_q, run_min_sub_q;
  logic [CNT_W-1:0] run_min_add_d, run_min_sub_d;
  logic [CNT_W-1:0] beat_min_add, beat_min_sub;
  logic [CNT_W-1:0] bank_sh_add_q [2];
  logic [CNT_W-1:0] bank_sh_sub_q [2];

  // Leading bits equal to the MSB, not counting the MSB itself.
  function automatic logic [CNT_W-1:0] rsb(input logic [INPUT_WIDTH-1:0] x);
    logic [CNT_W-1:0] n;
    logic             run;
    n   = '0;
    run = 1'b1;
    for (int i = INPUT_WIDTH - 2; i >= 0; i--) begin
      if (run && (x[i] == x[INPUT_WIDTH-1])) n = n + CNT_W'(1);
      else run = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [SHIFT_WIDTH-1:0] to_shift(input logic [CNT_W-1:0] c);
`ifdef CBFP1_SHIFT_CLAMP_EN
    if (int'(c) > SHIFT_TARGET) return SHIFT_WIDTH'(SHIFT_TARGET);
    else return SHIFT_WIDTH'(c);
`else
    return SHIFT_WIDTH'(c);
`endif
  endfunction

  always_comb begin
    beat_min_add = CNT_MAX;
    beat_min_sub = CNT_MAX;
    for (int l = 0; l < BLOCK_SIZE; l++) begin
      if (rsb(in_data_R_add[l]) < beat_min_add) beat_min_add = rsb(in_data_R_add[l]);
      if (rsb(in_data_Q_add[l]) < beat_min_add) beat_min_add = rsb(in_data_Q_add[l]);
      if (rsb(in_data_R_sub[l]) < beat_min_sub) beat_min_sub = rsb(in_data_R_sub[l]);
      if (rsb(in_data_Q_sub[l]) < beat_min_sub) beat_min_sub = rsb(in_data_Q_sub[l]);
    end
    run_min_add_d = (beat_min_add < run_min_add_q) ? beat_min_add : run_min_add_q;
    run_min_sub_d = (beat_min_sub < run_min_sub_q) ? beat_min_sub : run_min_sub_q;
  end

  // Beat storage carries no reset; the full flags decide what is valid.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int l = 0; l < BLOCK_SIZE; l++) begin
        mem_ra[fill_ptr_q][beat_cnt_q][l] <= in_data_R_add[l];
        mem_qa[fill_ptr_q][beat_cnt_q][l] <= in_data_Q_add[l];
        mem_rs[fill_ptr_q][beat_cnt_q][l] <= in_data_R_sub[l];
        mem_qs[fill_ptr_q][beat_cnt_q][l] <= in_data_Q_sub[l];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q       <= '0;
      drain_cnt_q      <= '0;
      fill_ptr_q       <= 1'b0;
      drain_ptr_q      <= 1'b0;
      full_q           <= '0;
      run_min_add_q    <= CNT_MAX;
      run_min_sub_q    <= CNT_MAX;
      bank_sh_add_q[0] <= '0;
      bank_sh_add_q[1] <= '0;
      bank_sh_sub_q[0] <= '0;
      bank_sh_sub_q[1] <= '0;
      out_valid        <= 1'b0;
      out_first        <= 1'b0;
      out_last         <= 1'b0;
      shift_value_add  <= '0;
      shift_value_sub  <= '0;
      for (int l = 0; l < BLOCK_SIZE; l++) begin
        out_data_R_add[l] <= '0;
        out_data_Q_add[l] <= '0;
        out_data_R_sub[l] <= '0;
        out_data_Q_sub[l] <= '0;
      end
    end else begin
      if (in_valid) begin
        if (beat_cnt_q == LAST_BEAT) begin
          bank_sh_add_q[fill_ptr_q] <= run_min_add_d;
          bank_sh_sub_q[fill_ptr_q] <= run_min_sub_d;
          full_q[fill_ptr_q]        <= 1'b1;
          fill_ptr_q                <= ~fill_ptr_q;
          beat_cnt_q                <= '0;
          run_min_add_q             <= CNT_MAX;
          run_min_sub_q             <= CNT_MAX;
        end else begin
          beat_cnt_q    <= beat_cnt_q + BW'(1);
          run_min_add_q <= run_min_add_d;
          run_min_sub_q <= run_min_sub_d;
        end
      end

      // The drain bank is always the other bank from the fill bank while it is full.
      if (full_q[drain_ptr_q]) begin
        out_valid       <= 1'b1;
        out_first       <= (drain_cnt_q == '0);
        out_last        <= (drain_cnt_q == LAST_BEAT);
        shift_value_add <= to_shift(bank_sh_add_q[drain_ptr_q]);
        shift_value_sub <= to_shift(bank_sh_sub_q[drain_ptr_q]);
        for (int l = 0; l < BLOCK_SIZE; l++) begin
          out_data_R_add[l] <= mem_ra[drain_ptr_q][drain_cnt_q][l];
          out_data_Q_add[l] <= mem_qa[drain_ptr_q][drain_cnt_q][l];
          out_data_R_sub[l] <= mem_rs[drain_ptr_q][drain_cnt_q][l];
          out_data_Q_sub[l] <= mem_qs[drain_ptr_q][drain_cnt_q][l];
        end
        if (drain_cnt_q == LAST_BEAT) begin
          full_q[drain_ptr_q] <= 1'b0;
          drain_ptr_q         <= ~drain_ptr_q;
          drain_cnt_q         <= '0;
        end else begin
          drain_cnt_q <= drain_cnt_q + BW'(1);
        end
      end else begin
        out_valid <= 1'b0;
        out_first <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cbfp1_shift_calc.sv
// Bench for cbfp1_shift_calc: vector table of known groups, random traffic against a
// group-level reference model, and asynchronous reset corner cases.
module tb_cbfp1_shift_calc;
  localparam int IW = 25;
  localparam int BS = 8;
  localparam int SW = 5;
  localparam int BB = 2;
  localparam int ST = 13;

  typedef struct packed {
    logic [BS-1:0][IW-1:0] ra, qa, rs, qs;
  } beat_t;

  typedef struct packed {
    logic          first, last;
    logic [SW-1:0] sha, shs;
    beat_t         d;
  } out_t;

  localparam int OW = $bits(out_t);

  typedef struct {
    logic [IW-1:0] bg_add, bg_sub;
    int            p1, l1, b1;
    logic [IW-1:0] v1;
    int            p2, l2, b2;
    logic [IW-1:0] v2;
    int            sha, shs;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic signed [IW-1:0] in_ra [BS], in_qa [BS], in_rs [BS], in_qs [BS];
  logic out_valid, out_first, out_last;
  logic signed [IW-1:0] o_ra [BS], o_qa [BS], o_rs [BS], o_qs [BS];
  logic [SW-1:0] shift_value_add, shift_value_sub;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [OW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  beat_t         grp[$];
  beat_t         last_d = '0;
  vec_t          tbl[6];

  cbfp1_shift_calc dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_data_R_add(in_ra), .in_data_Q_add(in_qa),
    .in_data_R_sub(in_rs), .in_data_Q_sub(in_qs),
    .out_valid(out_valid), .out_first(out_first), .out_last(out_last),
    .out_data_R_add(o_ra), .out_data_Q_add(o_qa),
    .out_data_R_sub(o_rs), .out_data_Q_sub(o_qs),
    .shift_value_add(shift_value_add), .shift_value_sub(shift_value_sub)
  );

  // Clock and cycle index
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: smallest n with -2^n <= v < 2^n gives IW-1-n redundant sign bits.
  function automatic int rsb_model(input logic [IW-1:0] v);
    int val;
    val = int'($signed(v));
    for (int n = 0; n < IW; n++)
      if (val >= -(1 << n) && val < (1 << n)) return IW - 1 - n;
    return 0;
  endfunction

  function automatic int clampf(input int x);
`ifdef CBFP1_SHIFT_CLAMP_EN
    return (x > ST) ? ST : x;
`else
    return x;
`endif
  endfunction

  function automatic out_t cur_out();
    out_t a;
    a.first = out_first;
    a.last  = out_last;
    a.sha   = shift_value_add;
    a.shs   = shift_value_sub;
    for (int l = 0; l < BS; l++) begin
      a.d.ra[l] = o_ra[l];
      a.d.qa[l] = o_qa[l];
      a.d.rs[l] = o_rs[l];
      a.d.qs[l] = o_qs[l];
    end
    return a;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, expv);
    end
  endtask

  task automatic model_accept(input beat_t b);
    int   ma, ms;
    out_t o;
    grp.push_back(b);
    if (grp.size() == BB) begin
      ma = IW - 1;
      ms = IW - 1;
      foreach (grp[j])
        for (int l = 0; l < BS; l++) begin
          ma = (rsb_model(grp[j].ra[l]) < ma) ? rsb_model(grp[j].ra[l]) : ma;
          ma = (rsb_model(grp[j].qa[l]) < ma) ? rsb_model(grp[j].qa[l]) : ma;
          ms = (rsb_model(grp[j].rs[l]) < ms) ? rsb_model(grp[j].rs[l]) : ms;
          ms = (rsb_model(grp[j].qs[l]) < ms) ? rsb_model(grp[j].qs[l]) : ms;
        end
      for (int j = 0; j < BB; j++) begin
        o.first = (j == 0);
        o.last  = (j == BB - 1);
        o.sha   = SW'(clampf(ma));
        o.shs   = SW'(clampf(ms));
        o.d     = grp[j];
        exp_q.push_back(o);
        exp_cyc_q.push_back(cyc + 1 + j);
      end
      grp.delete();
    end
  endtask

  // Scoreboard: every cycle either an expected beat or an idle cycle holding the last data.
  always @(negedge clk) begin
    out_t a, e;
    a = cur_out();
    if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
      chk("missed_beat", 256'(cyc), 256'(exp_cyc_q[0]));
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
    end
    if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
      e = exp_q.pop_front();
      void'(exp_cyc_q.pop_front());
      chk("beat_ctrl", 256'({out_valid, a.first, a.last, a.sha, a.shs}),
          256'({1'b1, e.first, e.last, e.sha, e.shs}));
      chk("beat_r_add", 256'(a.d.ra), 256'(e.d.ra));
      chk("beat_q_add", 256'(a.d.qa), 256'(e.d.qa));
      chk("beat_r_sub", 256'(a.d.rs), 256'(e.d.rs));
      chk("beat_q_sub", 256'(a.d.qs), 256'(e.d.qs));
      last_d = e.d;
    end else begin
      chk("idle_ctrl", 256'({out_valid, out_first, out_last}), 256'(0));
      chk("idle_hold", 256'(a.d), 256'(last_d));
    end
  end

  // Drivers
  task automatic drive(input beat_t b, input bit v);
    in_valid = v;
    for (int l = 0; l < BS; l++) begin
      in_ra[l] = b.ra[l];
      in_qa[l] = b.qa[l];
      in_rs[l] = b.rs[l];
      in_qs[l] = b.qs[l];
    end
    @(posedge clk);
    #1;
    if (v && !rst) model_accept(b);
  endtask

  function automatic logic [IW-1:0] rand_sample(input int nmax);
    logic [IW-1:0] v;
    int n;
    n = $urandom_range(0, nmax);
    v = IW'($urandom) & IW'((1 << n) - 1);
    if ($urandom_range(0, 1) == 1) v = ~v;
    return v;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    int na, ns;
    na = $urandom_range(0, IW - 1);
    ns = $urandom_range(0, IW - 1);
    for (int l = 0; l < BS; l++) begin
      b.ra[l] = rand_sample(na);
      b.qa[l] = rand_sample(na);
      b.rs[l] = rand_sample(ns);
      b.qs[l] = rand_sample(ns);
    end
    return b;
  endfunction

  function automatic beat_t poke(input beat_t b, input int p, input int l, input logic [IW-1:0] v);
    beat_t r;
    r = b;
    case (p)
      0: r.ra[l] = v;
      1: r.qa[l] = v;
      2: r.rs[l] = v;
      3: r.qs[l] = v;
      default: ;
    endcase
    return r;
  endfunction

  function automatic beat_t build(input vec_t e, input int bt);
    beat_t b;
    for (int l = 0; l < BS; l++) begin
      b.ra[l] = e.bg_add;
      b.qa[l] = e.bg_add;
      b.rs[l] = e.bg_sub;
      b.qs[l] = e.bg_sub;
    end
    if (e.b1 == bt) b = poke(b, e.p1, e.l1, e.v1);
    if (e.b2 == bt) b = poke(b, e.p2, e.l2, e.v2);
    return b;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(rand_beat(), 1'b0);
  endtask

  task automatic check_zero_outputs(input string nm);
    out_t a;
    a = cur_out();
    chk({nm, "_ctrl"}, 256'({out_valid, a.first, a.last, a.sha, a.shs}), 256'(0));
    chk({nm, "_data"}, 256'(a.d.ra ^ a.d.qa ^ a.d.rs ^ a.d.qs), 256'(0));
    chk({nm, "_dra"}, 256'(a.d.ra), 256'(0));
  endtask

  // Assert reset mid-cycle, check outputs clear at once, drop all model state, release later.
  task automatic async_reset(input string nm);
    #2;
    rst = 1'b1;
    grp.delete();
    exp_q.delete();
    exp_cyc_q.delete();
    last_d = '0;
    #1;
    check_zero_outputs(nm);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    beat_t b;
    tbl[0] = '{25'h0, 25'h0, -1, 0, 0, 25'h0, -1, 0, 0, 25'h0, 24, 24};
    tbl[1] = '{25'h0, 25'h1FFFFFF, 0, 3, 0, 25'd4095, 1, 5, 1, 25'h1FFF000, 12, 24};
    tbl[2] = '{25'h0, 25'h0, 3, 0, 0, 25'h0FFFFFF, -1, 0, 0, 25'h0, 24, 0};
    tbl[3] = '{25'h0, 25'h0, 3, 0, 1, 25'h1000000, -1, 0, 0, 25'h0, 24, 0};
    tbl[4] = '{25'h0, 25'h0, 0, 7, 1, 25'h1000000, 2, 2, 0, 25'd5, 0, 21};
    tbl[5] = '{25'h1FFFFFF, 25'h0, 1, 0, 0, 25'h1FFFFFE, 3, 6, 1, 25'd256, 23, 15};

    rst = 1'b0;
    in_valid = 1'b0;
    for (int l = 0; l < BS; l++) begin
      in_ra[l] = '0; in_qa[l] = '0; in_rs[l] = '0; in_qs[l] = '0;
    end
    #1 rst = 1'b1;
    #1 check_zero_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;

    // Vector table: known groups with hand-derived shift values
    foreach (tbl[i]) begin
      drive(build(tbl[i], 0), 1'b1);
      drive(build(tbl[i], 1), 1'b1);
      drive(rand_beat(), 1'b0);
      @(negedge clk);
      #1;
      chk("tbl_first", 256'({out_valid, out_first, out_last}), 256'(3'b110));
      chk("tbl_sha", 256'(shift_value_add), 256'(clampf(tbl[i].sha)));
      chk("tbl_shs", 256'(shift_value_sub), 256'(clampf(tbl[i].shs)));
      idle(2);
    end

    // Continuous: 10 beats back to back
    for (int i = 0; i < 10; i++) drive(rand_beat(), 1'b1);
    idle(3);

    // Gapped: one valid beat in three cycles
    for (int i = 0; i < 10; i++) begin
      drive(rand_beat(), 1'b1);
      idle(2);
    end
    idle(2);

    // Random valid pattern
    for (int i = 0; i < 60; i++) drive(rand_beat(), 1'($urandom_range(0, 1)));
    idle(3);

    // Reset after beat 0 of a group whose count is 0; the next group must start fresh
    for (int l = 0; l < BS; l++) begin
      b.ra[l] = 25'h0FFFFFF; b.qa[l] = 25'h1000000;
      b.rs[l] = 25'h0FFFFFF; b.qs[l] = 25'h1000000;
    end
    drive(b, 1'b1);
    async_reset("rst_mid_group");
    drive(build(tbl[0], 0), 1'b1);
    drive(build(tbl[0], 1), 1'b1);
    drive(rand_beat(), 1'b0);
    @(negedge clk);
    #1;
    chk("post_rst_sha", 256'(shift_value_add), 256'(clampf(24)));
    chk("post_rst_shs", 256'(shift_value_sub), 256'(clampf(24)));
    idle(2);

    // Reset while a group drains; no stale beats may follow
    drive(rand_beat(), 1'b1);
    drive(rand_beat(), 1'b1);
    drive(rand_beat(), 1'b1);
    async_reset("rst_mid_drain");
    idle(4);
    for (int i = 0; i < 6; i++) drive(rand_beat(), 1'b1);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1);
    chk("drain_empty", 256'(exp_q.size()), 256'(0));
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
